// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and program-counter stage for the multi-cycle core.
// Holds the architectural PC, fetches one instruction at a time over a valid/ready
// request and valid-only response interface, presents it to decode, then waits for
// the retire pulse and computes the next PC from the control-transfer select.
//
// Ports:
//   clock, reset_n                 core clock, async active-low reset
//   imem_req_valid/ready/addr      fetch request (addr always equals pc)
//   imem_rsp_valid/data            fetch response
//   inst_valid/ready, inst,inst_pc instruction handed to decode
//   retire_valid, next_pc_select   retire pulse and next-PC select
//   branch_target, jalr_target     redirect targets from execute
//   fetch_exception, exception_pc  misaligned-target pulse and offending target
//   retired_count                  count of accepted retire pulses
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        retire_valid,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic        fetch_exception,
  output logic [31:0] exception_pc,
  output logic [63:0] retired_count
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StIssue, StExec} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        exc_q, exc_d;
  logic [31:0] exception_pc_q, exception_pc_d;
  logic [63:0] count_q, count_d;
  logic [31:0] cand_pc;

  // Candidate next PC, before the alignment check.
  always_comb begin
    unique case (next_pc_select)
      2'b00:   cand_pc = pc_q + 32'd4;
      2'b01:   cand_pc = branch_target;
      2'b10:   cand_pc = jalr_target & 32'hFFFF_FFFE;
      default: cand_pc = TRAP_VECTOR;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    exc_d          = 1'b0;
    exception_pc_d = exception_pc_q;
    count_d        = count_q;
    unique case (state_q)
      StReq: begin
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_rsp_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (inst_ready) state_d = StExec;
      end
      StExec: begin
        if (retire_valid) begin
          count_d = count_q + 64'd1;
          state_d = StReq;
          // Only bit 1 decides misalignment; bit 0 of a branch target is ignored.
          if (cand_pc[1]) begin
            pc_d           = TRAP_VECTOR;
            exc_d          = 1'b1;
            exception_pc_d = cand_pc;
          end else begin
            pc_d = cand_pc;
          end
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StReq;
      pc_q           <= RESET_PC;
      inst_q         <= Nop;
      inst_pc_q      <= RESET_PC;
      exc_q          <= 1'b0;
      exception_pc_q <= 32'h0;
      count_q        <= 64'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      inst_pc_q      <= inst_pc_d;
      exc_q          <= exc_d;
      exception_pc_q <= exception_pc_d;
      count_q        <= count_d;
    end
  end

  // Handshake valids depend on state only, never on same-cycle ready.
  assign imem_req_valid  = (state_q == StReq);
  assign inst_valid      = (state_q == StIssue);
  assign imem_req_addr   = pc_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;
  assign fetch_exception = exc_q;
  assign exception_pc    = exception_pc_q;
  assign retired_count   = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] TrapVec = 32'h0000_0100;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        retire_valid = 1'b0;
  logic [1:0]  next_pc_select = 2'b00;
  logic [31:0] branch_target = 32'h0, jalr_target = 32'h0;
  logic        fetch_exception;
  logic [31:0] exception_pc;
  logic [63:0] retired_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference state: architectural PC, retire count, last exception target.
  logic [31:0] m_pc;
  logic [63:0] m_count;
  logic [31:0] m_exc_pc;

  // Observations from one instruction round trip.
  logic [31:0] o_addr, o_inst, o_pc, o_exc_pc;
  logic        o_stable, o_exc1, o_exc2, o_to;
  int          o_lat;

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .retire_valid   (retire_valid),
    .next_pc_select (next_pc_select),
    .branch_target  (branch_target),
    .jalr_target    (jalr_target),
    .fetch_exception(fetch_exception),
    .exception_pc   (exception_pc),
    .retired_count  (retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = ResetPc; m_count = 64'd0; m_exc_pc = 32'd0;
  endtask

  // Applies a retire to the reference; returns whether an exception is expected.
  function automatic logic model_retire(input logic [1:0] sel, input logic [31:0] bt,
                                        input logic [31:0] jt);
    logic [31:0] t;
    case (sel)
      2'd0:    t = m_pc + 32'd4;
      2'd1:    t = bt;
      2'd2:    t = jt - (jt % 2);
      default: t = TrapVec;
    endcase
    m_count = m_count + 1;
    if ((t % 4) >= 2) begin
      m_exc_pc = t;
      m_pc = TrapVec;
      return 1'b1;
    end
    m_pc = t;
    return 1'b0;
  endfunction

  // Drives one full fetch/issue/retire round trip; all timing is on the negedge.
  task automatic run_instr(input int req_dly, input int rsp_dly, input int iss_dly,
                           input int ret_dly, input bit stray, input logic [1:0] sel,
                           input logic [31:0] bt, input logic [31:0] jt,
                           input logic [31:0] data);
    o_to = 1'b0; o_stable = 1'b1; o_lat = 0; o_exc1 = 1'bx; o_exc2 = 1'bx;
    o_addr = 'x; o_inst = 'x; o_pc = 'x; o_exc_pc = 'x;
    for (int i = 0; i < 50 && !imem_req_valid; i++) @(negedge clock);
    if (!imem_req_valid) begin o_to = 1'b1; return; end
    o_addr = imem_req_addr;
    for (int i = 0; i < req_dly; i++) begin
      imem_rsp_valid = stray; imem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clock);
      if (imem_req_addr !== o_addr || imem_req_valid !== 1'b1) o_stable = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0; o_lat = 1;
    for (int i = 0; i < rsp_dly; i++) begin @(negedge clock); o_lat++; end
    imem_rsp_valid = 1'b1; imem_rsp_data = data;
    @(negedge clock);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; o_lat++;
    for (int i = 0; i < 50 && !inst_valid; i++) begin @(negedge clock); o_lat++; end
    if (!inst_valid) begin o_to = 1'b1; return; end
    o_inst = inst; o_pc = inst_pc;
    for (int i = 0; i < iss_dly; i++) begin
      retire_valid = stray && (i == 0);
      @(negedge clock);
      retire_valid = 1'b0;
      if (inst !== o_inst || inst_pc !== o_pc || inst_valid !== 1'b1) o_stable = 1'b0;
    end
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    for (int i = 0; i < ret_dly; i++) @(negedge clock);
    retire_valid = 1'b1; next_pc_select = sel; branch_target = bt; jalr_target = jt;
    @(negedge clock);
    retire_valid = 1'b0;
    o_exc1 = fetch_exception; o_exc_pc = exception_pc;
    @(negedge clock);
    o_exc2 = fetch_exception;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    total_cnt++; if (imem_req_addr !== ResetPc) $display("FAIL rst_addr got %h exp %h", imem_req_addr, ResetPc); else pass_cnt++;
    total_cnt++; if (inst !== Nop) $display("FAIL rst_inst got %h exp %h", inst, Nop); else pass_cnt++;
    total_cnt++; if (inst_pc !== ResetPc) $display("FAIL rst_inst_pc got %h exp %h", inst_pc, ResetPc); else pass_cnt++;
    total_cnt++; if ({inst_valid, fetch_exception} !== 2'b00) $display("FAIL rst_valids got %b exp 00", {inst_valid, fetch_exception}); else pass_cnt++;
    total_cnt++; if (exception_pc !== 32'h0 || retired_count !== 64'h0) $display("FAIL rst_regs got %h/%0d exp 0/0", exception_pc, retired_count); else pass_cnt++;
    reset_n = 1'b1;
    model_reset();
    total_cnt++; if (imem_req_valid !== 1'b1) $display("FAIL rst_req_valid got %b exp 1", imem_req_valid); else pass_cnt++;
  endtask

  task automatic test_first_fetch();
    logic e;
    run_instr(0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, Nop);
    total_cnt++; if (o_to) $display("FAIL first_timeout got timeout exp progress"); else pass_cnt++;
    total_cnt++; if (o_addr !== ResetPc) $display("FAIL first_addr got %h exp %h", o_addr, ResetPc); else pass_cnt++;
    total_cnt++; if (o_lat !== 2) $display("FAIL first_latency got %0d exp 2", o_lat); else pass_cnt++;
    total_cnt++; if (o_pc !== ResetPc || o_inst !== Nop) $display("FAIL first_inst got %h@%h exp %h@%h", o_inst, o_pc, Nop, ResetPc); else pass_cnt++;
    e = model_retire(2'b00, 32'h0, 32'h0);
    total_cnt++; if (imem_req_addr !== m_pc) $display("FAIL first_next_pc got %h exp %h", imem_req_addr, m_pc); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic e;
    logic [31:0] exp_addr [3] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
    logic [63:0] start_count;
    start_count = m_count;
    for (int k = 0; k < 3; k++) begin
      run_instr(0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h1000_0000 + k);
      total_cnt++; if (o_addr !== exp_addr[k]) $display("FAIL seq_addr%0d got %h exp %h", k, o_addr, exp_addr[k]); else pass_cnt++;
      e = model_retire(2'b00, 32'h0, 32'h0);
    end
    total_cnt++; if (retired_count !== start_count + 3) $display("FAIL seq_count got %0d exp %0d", retired_count, start_count + 3); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic e;
    logic [31:0] a;
    a = m_pc;
    run_instr(5, 2, 4, 3, 1'b0, 2'b00, 32'h0, 32'h0, 32'hCAFE_0001);
    total_cnt++; if (o_stable !== 1'b1 || o_to) $display("FAIL bp_stable got %b exp 1", o_stable); else pass_cnt++;
    total_cnt++; if (o_addr !== a || o_inst !== 32'hCAFE_0001 || o_pc !== a) $display("FAIL bp_inst got %h@%h exp %h@%h", o_inst, o_pc, 32'hCAFE_0001, a); else pass_cnt++;
    e = model_retire(2'b00, 32'h0, 32'h0);
    total_cnt++; if (retired_count !== m_count) $display("FAIL bp_count got %0d exp %0d", retired_count, m_count); else pass_cnt++;
  endtask

  task automatic test_redirects();
    logic e;
    run_instr(0, 0, 0, 0, 1'b0, 2'b01, 32'h0040_0100, 32'h0, Nop);
    e = model_retire(2'b01, 32'h0040_0100, 32'h0);
    total_cnt++; if (imem_req_addr !== 32'h0040_0100) $display("FAIL br_addr got %h exp %h", imem_req_addr, 32'h0040_0100); else pass_cnt++;
    run_instr(0, 1, 0, 2, 1'b0, 2'b10, 32'h0, 32'h0040_0203, Nop);
    e = model_retire(2'b10, 32'h0, 32'h0040_0203);
    total_cnt++; if (o_exc1 !== 1'b1 || o_exc2 !== 1'b0) $display("FAIL jalr_exc_pulse got %b%b exp 10", o_exc1, o_exc2); else pass_cnt++;
    total_cnt++; if (o_exc_pc !== 32'h0040_0202) $display("FAIL jalr_exc_pc got %h exp %h", o_exc_pc, 32'h0040_0202); else pass_cnt++;
    total_cnt++; if (imem_req_addr !== TrapVec) $display("FAIL jalr_trap_addr got %h exp %h", imem_req_addr, TrapVec); else pass_cnt++;
    run_instr(0, 0, 0, 0, 1'b0, 2'b11, 32'h0, 32'h0, Nop);
    e = model_retire(2'b11, 32'h0, 32'h0);
    total_cnt++; if (o_exc1 !== 1'b0 || imem_req_addr !== TrapVec) $display("FAIL trap_sel got exc=%b addr=%h exp exc=0 addr=%h", o_exc1, imem_req_addr, TrapVec); else pass_cnt++;
    total_cnt++; if (exception_pc !== 32'h0040_0202) $display("FAIL exc_pc_hold got %h exp %h", exception_pc, 32'h0040_0202); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic e;
    run_instr(0, 0, 0, 0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, Nop);
    e = model_retire(2'b01, 32'hFFFF_FFFC, 32'h0);
    run_instr(0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, Nop);
    total_cnt++; if (o_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_from got %h exp %h", o_addr, 32'hFFFF_FFFC); else pass_cnt++;
    e = model_retire(2'b00, 32'h0, 32'h0);
    total_cnt++; if (imem_req_addr !== 32'h0 || o_exc1 !== 1'b0) $display("FAIL wrap_to got %h exc=%b exp 00000000 exc=0", imem_req_addr, o_exc1); else pass_cnt++;
  endtask

  task automatic test_stray();
    logic e;
    run_instr(2, 0, 3, 0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h1234_5678);
    total_cnt++; if (o_inst !== 32'h1234_5678) $display("FAIL stray_rsp got %h exp %h", o_inst, 32'h1234_5678); else pass_cnt++;
    e = model_retire(2'b00, 32'h0, 32'h0);
    total_cnt++; if (retired_count !== m_count) $display("FAIL stray_retire_count got %0d exp %0d", retired_count, m_count); else pass_cnt++;
    total_cnt++; if (imem_req_addr !== m_pc) $display("FAIL stray_next_pc got %h exp %h", imem_req_addr, m_pc); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // Move into WAIT, reset there, then present a late response.
    for (int i = 0; i < 50 && !imem_req_valid; i++) @(negedge clock);
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (retired_count !== 64'h0 || imem_req_addr !== ResetPc || exception_pc !== 32'h0) $display("FAIL midrst_async got cnt=%0d addr=%h epc=%h exp 0/%h/0", retired_count, imem_req_addr, exception_pc, ResetPc); else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    @(negedge clock);
    total_cnt++; if (inst_valid !== 1'b0 || inst !== Nop) $display("FAIL midrst_discard got valid=%b inst=%h exp 0/%h", inst_valid, inst, Nop); else pass_cnt++;
    run_instr(0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0093);
    total_cnt++; if (o_addr !== ResetPc || o_inst !== 32'h0000_0093) $display("FAIL midrst_refetch got %h:%h exp %h:%h", o_addr, o_inst, ResetPc, 32'h0000_0093); else pass_cnt++;
    void'(model_retire(2'b00, 32'h0, 32'h0));
  endtask

  task automatic test_random();
    logic        e;
    logic [1:0]  sel;
    logic [31:0] bt, jt, d, a;
    for (int k = 0; k < 40; k++) begin
      sel = 2'($urandom_range(0, 3));
      bt = $urandom; jt = $urandom; d = $urandom;
      a = m_pc;
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), sel, bt, jt, d);
      e = model_retire(sel, bt, jt);
      total_cnt++;
      if (o_to || o_stable !== 1'b1 || o_addr !== a || o_inst !== d || o_pc !== a ||
          o_exc1 !== e || o_exc2 !== 1'b0 || o_exc_pc !== m_exc_pc ||
          retired_count !== m_count || imem_req_addr !== m_pc)
        $display("FAIL rand%0d got addr=%h inst=%h pc=%h exc=%b%b epc=%h cnt=%0d next=%h stable=%b exp addr=%h inst=%h exc=%b0 epc=%h cnt=%0d next=%h",
                 k, o_addr, o_inst, o_pc, o_exc1, o_exc2, o_exc_pc, retired_count, imem_req_addr,
                 o_stable, a, d, e, m_exc_pc, m_count, m_pc);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    test_first_fetch();
    test_sequential();
    test_backpressure();
    test_redirects();
    test_wrap();
    test_stray();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
